// File: rtl/mem_burst_responder_pkg.sv
// Shared cache definitions: line geometry macros, burst FSM state encoding
// and the words-per-line derivation used by the burst responder.
`ifndef CACHE_B
`define CACHE_B 4
`endif
`ifndef CACHE_T
`define CACHE_T 22
`endif

package mem_burst_responder_pkg;

   // Width of one backing-store word / bus beat.
   localparam int WORD_W = 32;

   // Burst responder FSM states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_READ  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } burst_state_e;

   // Number of 32-bit words in a cache line with the given byte-offset width.
   function automatic int line_size(input int offset_width);
      return 1 << (offset_width - 2);
   endfunction

endpackage

// File: rtl/mem_burst_responder_mem_array.sv
// Backing store for the burst responder: one port, synchronous write,
// asynchronous (combinational) read. Contents are never reset.
module mem_array
   import mem_burst_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WORD_W-1:0]     wdata_i,
   output logic [WORD_W-1:0]     rdata_o
);

   logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];

   // Write port: store the beat on the clock edge when enabled.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_burst_responder.sv
// Cache-line burst responder: accepts one line request at a time, waits a
// fixed latency, then streams a refill burst out or sinks a write-back burst
// into the backing store, finishing with a one-cycle done pulse.
`ifndef CACHE_B
`define CACHE_B 4
`endif

module mem_burst_responder
   import mem_burst_responder_pkg::*;
#(
   parameter int OFFSET_WIDTH = `CACHE_B,
   parameter int ADDR_WIDTH   = 10,
   parameter int LATENCY      = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_write_i,
   input  logic [31:0]             req_addr_i,
   output logic                    rvalid_o,
   output logic [31:0]             rdata_o,
   input  logic                    wvalid_i,
   output logic                    wready_o,
   input  logic [31:0]             wdata_i,
   output logic [OFFSET_WIDTH-3:0] beat_offset_o,
   output logic                    last_o,
   output logic                    done_o
);

   localparam int BEAT_W    = OFFSET_WIDTH - 2;
   localparam int LINE_SIZE = line_size(OFFSET_WIDTH);
   localparam int BASE_W    = ADDR_WIDTH - BEAT_W;
   localparam int LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_SIZE - 1);
   localparam logic [LAT_W-1:0]  LAT_ZERO  = LAT_W'(0);
   localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);
   // WAIT is entered with LATENCY-1 loaded and left when the count hits zero,
   // giving exactly LATENCY cycles in WAIT.
   localparam logic [LAT_W-1:0]  LAT_LOAD  = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : LAT_W'(0);

   burst_state_e      state_q, state_d;
   logic [BEAT_W-1:0] beat_q,  beat_d;
   logic [LAT_W-1:0]  lat_q,   lat_d;
   logic [BASE_W-1:0] base_q,  base_d;
   logic              write_q, write_d;

   logic [ADDR_WIDTH-1:0] mem_addr_s;
   logic [31:0]           mem_rdata_s;
   logic                  mem_we_s;
   logic                  in_burst_s;

   // Address bits outside the line-aligned word address are intentionally dropped.
   logic unused_addr_s;
   assign unused_addr_s = ^{req_addr_i[31:ADDR_WIDTH+2], req_addr_i[OFFSET_WIDTH-1:0]};

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         beat_q  <= BEAT_ZERO;
         lat_q   <= LAT_ZERO;
         base_q  <= {BASE_W{1'b0}};
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         lat_q   <= lat_d;
         base_q  <= base_d;
         write_q <= write_d;
      end
   end

   // Next-state logic: request capture, latency countdown and beat stepping.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      lat_d   = lat_q;
      base_d  = base_q;
      write_d = write_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               base_d  = req_addr_i[ADDR_WIDTH+1:OFFSET_WIDTH];
               write_d = req_write_i;
               beat_d  = BEAT_ZERO;
               lat_d   = LAT_LOAD;
               if (LATENCY > 0) begin
                  state_d = ST_WAIT;
               end else if (req_write_i) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (lat_q == LAT_ZERO) begin
               state_d = write_q ? ST_WRITE : ST_READ;
            end else begin
               lat_d = lat_q - LAT_ONE;
            end
         end
         ST_READ: begin
            // Refill never stalls: one beat per cycle.
            beat_d = beat_q + BEAT_ONE;
            if (beat_q == LAST_BEAT) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_WRITE: begin
            if (wvalid_i) begin
               beat_d = beat_q + BEAT_ONE;
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WRITE;
               end
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_DONE: begin
            beat_d  = BEAT_ZERO;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            beat_d  = BEAT_ZERO;
         end
      endcase
   end

   assign in_burst_s = (state_q == ST_READ) || (state_q == ST_WRITE);
   assign mem_addr_s = {base_q, beat_q};
   assign mem_we_s   = (state_q == ST_WRITE) && wvalid_i;

   // Outputs decoded from the current state; all idle values are zero.
   always_comb begin
      req_ready_o   = 1'b0;
      rvalid_o      = 1'b0;
      rdata_o       = 32'h0000_0000;
      wready_o      = 1'b0;
      beat_offset_o = BEAT_ZERO;
      last_o        = 1'b0;
      done_o        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
         end
         ST_READ: begin
            rvalid_o = 1'b1;
            rdata_o  = mem_rdata_s;
         end
         ST_WRITE: begin
            wready_o = 1'b1;
         end
         ST_DONE: begin
            done_o = 1'b1;
         end
         default: begin
            req_ready_o = 1'b0;
         end
      endcase
      if (in_burst_s) begin
         beat_offset_o = beat_q;
         last_o        = (beat_q == LAST_BEAT);
      end else begin
         beat_offset_o = BEAT_ZERO;
         last_o        = 1'b0;
      end
   end

   mem_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (mem_we_s),
      .addr_i  (mem_addr_s),
      .wdata_i (wdata_i),
      .rdata_o (mem_rdata_s)
   );

endmodule

// File: tb/tb_mem_burst_responder.sv
// Self-checking bench: one responder with LATENCY=2 (index 0) and one with
// LATENCY=0 (index 1), both with 4-word lines and a 1024-word store.
module tb_mem_burst_responder;

   localparam int AW = 10;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  off;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_s       [2];
   logic        req_valid_s [2];
   logic        req_write_s [2];
   logic [31:0] req_addr_s  [2];
   logic        wvalid_s    [2];
   logic [31:0] wdata_s     [2];
   logic        req_ready_s [2];
   logic        rvalid_s    [2];
   logic [31:0] rdata_s     [2];
   logic        wready_s    [2];
   logic [1:0]  beat_off_s  [2];
   logic        last_s      [2];
   logic        done_s      [2];

   int          lat_tab [2] = '{2, 0};
   logic [31:0] mdl [2][1024];
   beat_t       exp_q0 [$];
   beat_t       exp_q1 [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   mem_burst_responder #(.OFFSET_WIDTH(4), .ADDR_WIDTH(AW), .LATENCY(2)) dut_lat2 (
      .clk_i(clk), .rst_i(rst_s[0]), .req_valid_i(req_valid_s[0]), .req_ready_o(req_ready_s[0]),
      .req_write_i(req_write_s[0]), .req_addr_i(req_addr_s[0]), .rvalid_o(rvalid_s[0]),
      .rdata_o(rdata_s[0]), .wvalid_i(wvalid_s[0]), .wready_o(wready_s[0]), .wdata_i(wdata_s[0]),
      .beat_offset_o(beat_off_s[0]), .last_o(last_s[0]), .done_o(done_s[0]));

   mem_burst_responder #(.OFFSET_WIDTH(4), .ADDR_WIDTH(AW), .LATENCY(0)) dut_lat0 (
      .clk_i(clk), .rst_i(rst_s[1]), .req_valid_i(req_valid_s[1]), .req_ready_o(req_ready_s[1]),
      .req_write_i(req_write_s[1]), .req_addr_i(req_addr_s[1]), .rvalid_o(rvalid_s[1]),
      .rdata_o(rdata_s[1]), .wvalid_i(wvalid_s[1]), .wready_o(wready_s[1]), .wdata_i(wdata_s[1]),
      .beat_offset_o(beat_off_s[1]), .last_o(last_s[1]), .done_o(done_s[1]));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Refill monitor for the LATENCY=2 responder.
   always @(negedge clk) begin
      beat_t e;
      if (rvalid_s[0]) begin
         if (exp_q0.size() == 0) begin
            check("unexpected_beat0", 32'd1, 32'd0);
         end else begin
            e = exp_q0.pop_front();
            check("rdata0", rdata_s[0], e.data);
            check("roff0", 32'(beat_off_s[0]), 32'(e.off));
            check("rlast0", 32'(last_s[0]), 32'(e.last));
         end
      end
   end

   // Refill monitor for the LATENCY=0 responder.
   always @(negedge clk) begin
      beat_t e;
      if (rvalid_s[1]) begin
         if (exp_q1.size() == 0) begin
            check("unexpected_beat1", 32'd1, 32'd0);
         end else begin
            e = exp_q1.pop_front();
            check("rdata1", rdata_s[1], e.data);
            check("roff1", 32'(beat_off_s[1]), 32'(e.off));
            check("rlast1", 32'(last_s[1]), 32'(e.last));
         end
      end
   end

   function automatic int word_base(input logic [31:0] addr);
      return int'((addr >> 2) & 32'h0000_03FC);
   endfunction

   task automatic push_line(input int d, input logic [31:0] addr);
      beat_t e;
      int    base;
      base = word_base(addr);
      for (int b = 0; b < 4; b++) begin
         e.data = mdl[d][base + b];
         e.off  = 2'(b);
         e.last = (b == 3);
         if (d == 0) exp_q0.push_back(e);
         else        exp_q1.push_back(e);
      end
   endtask

   function automatic int q_size(input int d);
      return (d == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   task automatic check_idle_outputs(input int d, input string tag);
      check({tag, "_ready"}, 32'(req_ready_s[d]), 32'd1);
      check({tag, "_rvalid"}, 32'(rvalid_s[d]), 32'd0);
      check({tag, "_wready"}, 32'(wready_s[d]), 32'd0);
      check({tag, "_last"}, 32'(last_s[d]), 32'd0);
      check({tag, "_done"}, 32'(done_s[d]), 32'd0);
      check({tag, "_off"}, 32'(beat_off_s[d]), 32'd0);
      check({tag, "_rdata"}, rdata_s[d], 32'd0);
   endtask

   task automatic read_burst(input int d, input logic [31:0] addr, input string tag);
      int edges;
      int n;
      push_line(d, addr);
      @(negedge clk);
      check({tag, "_ready"}, 32'(req_ready_s[d]), 32'd1);
      req_valid_s[d] = 1'b1; req_write_s[d] = 1'b0; req_addr_s[d] = addr;
      @(posedge clk);
      #1 req_valid_s[d] = 1'b0;
      edges = 1;
      @(negedge clk);
      while (!rvalid_s[d] && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      check({tag, "_first_beat"}, 32'(edges), 32'(lat_tab[d] + 1));
      n = 0;
      while (!done_s[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_at"}, 32'(n), 32'd4);
      check({tag, "_q_empty"}, 32'(q_size(d)), 32'd0);
      @(negedge clk);
      check({tag, "_done_1cyc"}, 32'(done_s[d]), 32'd0);
      check({tag, "_ready_after"}, 32'(req_ready_s[d]), 32'd1);
   endtask

   task automatic write_burst(input int d, input logic [31:0] addr, input logic [31:0] base_data,
                              input int stall_beat, input int stall_len, input string tag);
      int edges;
      int beats;
      int stalled;
      int wcyc;
      int base;
      base = word_base(addr);
      @(negedge clk);
      check({tag, "_ready"}, 32'(req_ready_s[d]), 32'd1);
      req_valid_s[d] = 1'b1; req_write_s[d] = 1'b1; req_addr_s[d] = addr;
      @(posedge clk);
      #1 req_valid_s[d] = 1'b0;
      edges = 1;
      @(negedge clk);
      while (!wready_s[d] && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      check({tag, "_wready_at"}, 32'(edges), 32'(lat_tab[d] + 1));
      beats = 0; stalled = 0; wcyc = 0;
      while (beats < 4 && wcyc < 30) begin
         wcyc++;
         check({tag, "_off"}, 32'(beat_off_s[d]), 32'(beats));
         check({tag, "_wready"}, 32'(wready_s[d]), 32'd1);
         check({tag, "_last"}, 32'(last_s[d]), 32'(beats == 3));
         if (beats == stall_beat && stalled < stall_len) begin
            wvalid_s[d] = 1'b0;
            stalled++;
         end else begin
            wvalid_s[d] = 1'b1;
            wdata_s[d]  = base_data + 32'(beats);
            mdl[d][base + beats] = base_data + 32'(beats);
            beats++;
         end
         @(negedge clk);
      end
      wvalid_s[d] = 1'b0;
      check({tag, "_write_cycles"}, 32'(wcyc), 32'(4 + stall_len));
      check({tag, "_done"}, 32'(done_s[d]), 32'd1);
      check({tag, "_wready_off"}, 32'(wready_s[d]), 32'd0);
      @(negedge clk);
      check({tag, "_ready_after"}, 32'(req_ready_s[d]), 32'd1);
      check({tag, "_done_1cyc"}, 32'(done_s[d]), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      for (int d = 0; d < 2; d++) begin
         rst_s[d] = 1'b1; req_valid_s[d] = 1'b0; req_write_s[d] = 1'b0;
         req_addr_s[d] = 32'd0; wvalid_s[d] = 1'b0; wdata_s[d] = 32'd0;
      end
      repeat (3) @(negedge clk);
      check_idle_outputs(0, "reset0");
      check_idle_outputs(1, "reset1");
      rst_s[0] = 1'b0; rst_s[1] = 1'b0;

      // Basic write-back then refill of the same line (unaligned refill address).
      write_burst(0, 32'h0000_0040, 32'h0000_00A0, -1, 0, "wr_a");
      read_burst(0, 32'h0000_004C, "rd_a");

      // Write-back with wvalid_i low for 3 cycles on beat 1.
      write_burst(0, 32'h0000_0080, 32'h0000_00B0, 1, 3, "wr_stall");
      read_burst(0, 32'h0000_0080, "rd_stall");

      // Write data presented while idle must not touch memory.
      @(negedge clk);
      wvalid_s[0] = 1'b1; wdata_s[0] = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      wvalid_s[0] = 1'b0;
      read_burst(0, 32'h0000_0040, "rd_nojunk");

      // Reset on the second refill beat aborts the burst without done.
      push_line(0, 32'h0000_0080);
      @(negedge clk);
      req_valid_s[0] = 1'b1; req_write_s[0] = 1'b0; req_addr_s[0] = 32'h0000_0080;
      @(posedge clk);
      #1 req_valid_s[0] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(rvalid_s[0] && beat_off_s[0] == 2'd1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_beat2_reached", 32'(n), 32'd3);
      rst_s[0] = 1'b1;
      @(negedge clk);
      check_idle_outputs(0, "rst_mid");
      rst_s[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_done", 32'(done_s[0]), 32'd0);
      end
      exp_q0.delete();
      read_burst(0, 32'h0000_0080, "rd_after_rst");

      // Request held high through a burst: second accept only after done.
      push_line(0, 32'h0000_0040);
      push_line(0, 32'h0000_0040);
      @(negedge clk);
      req_valid_s[0] = 1'b1; req_write_s[0] = 1'b0; req_addr_s[0] = 32'h0000_0040;
      n = 0;
      @(negedge clk);
      while (!done_s[0] && n < 20) begin
         check("hold_busy_ready", 32'(req_ready_s[0]), 32'd0);
         @(negedge clk);
         n++;
      end
      check("hold_first_done", 32'(n), 32'd6);
      check("hold_ready_in_done", 32'(req_ready_s[0]), 32'd0);
      @(negedge clk);
      check("hold_ready_after_done", 32'(req_ready_s[0]), 32'd1);
      @(negedge clk);
      check("hold_second_accepted", 32'(req_ready_s[0]), 32'd0);
      req_valid_s[0] = 1'b0;
      n = 0;
      while (!done_s[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("hold_second_done", 32'(n), 32'd6);
      check("hold_q_empty", 32'(exp_q0.size()), 32'd0);

      // Zero-latency responder and word-address wrap.
      write_burst(1, 32'h0000_0000, 32'h0000_00C0, -1, 0, "wr0_l0");
      read_burst(1, 32'h0000_1000, "rd_wrap_l0");
      write_burst(1, 32'h0000_1010, 32'h0000_00D0, 2, 1, "wr_wrap_l0");
      read_burst(1, 32'h0000_0010, "rd_word4_l0");

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_burst_responder.md
MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 SHALL have parameter OFFSET_WIDTH, default `CACHE_B, byte-offset width of one cache line; LINE_SIZE = 2**(OFFSET_WIDTH-2) words per burst.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word-address width of backing store (2**ADDR_WIDTH 32-bit words).
REQ-003 SHALL have parameter LATENCY, default 2, idle cycles between request accept and first beat (0 legal).
REQ-004 SHALL have one clock and a synchronous active-high reset: clk_i  input  1  clock; rst_i  input  1  synchronous reset, active-high.
REQ-005 req_valid_i  input  1  line request present.
REQ-006 req_ready_o  output  1  responder can accept request.
REQ-007 req_write_i  input  1  1 = write-back burst, 0 = refill burst.
REQ-008 req_addr_i  input  32  byte address; bits [OFFSET_WIDTH-1:0] ignored (line-aligned).
REQ-009 rvalid_o  output  1  refill beat valid.
REQ-010 rdata_o  output  32  refill beat data.
REQ-011 wvalid_i  input  1  write-back beat valid.
REQ-012 wready_o  output  1  write-back beat accepted when high with wvalid_i.
REQ-013 wdata_i  input  32  write-back beat data.
REQ-014 beat_offset_o  output  OFFSET_WIDTH-2  word offset of current beat within line.
REQ-015 last_o  output  1  current beat is final beat.
REQ-016 done_o  output  1  one-cycle pulse: burst complete.

Function
REQ-017 SHALL implement states IDLE, WAIT, READ, WRITE, DONE.
REQ-018 req_ready_o SHALL be high only in IDLE; request accepted on posedge with req_valid_i && req_ready_o.
REQ-019 On accept, SHALL latch base = req_addr_i[ADDR_WIDTH+1:OFFSET_WIDTH], direction, clear beat counter; go to WAIT if LATENCY>0, else straight to READ/WRITE.
REQ-020 WAIT SHALL last exactly LATENCY cycles (down-counter), then go to READ or WRITE per latched direction.
REQ-021 READ: each cycle rvalid_o=1, rdata_o=mem[{base,beat}], beat increments; no backpressure; exactly LINE_SIZE consecutive beats.
REQ-022 WRITE: wready_o=1; on wvalid_i && wready_o, mem[{base,beat}] <= wdata_i and beat increments; wvalid_i low stalls without advancing.
REQ-023 beat_offset_o SHALL equal beat counter in READ/WRITE; last_o high when beat = LINE_SIZE-1 in READ/WRITE.
REQ-024 After final beat SHALL enter DONE for one cycle with done_o=1, then IDLE.
REQ-025 Word address SHALL wrap modulo 2**ADDR_WIDTH (upper address bits discarded).
REQ-026 req_valid_i outside IDLE SHALL be ignored; write-back data outside WRITE SHALL not alter memory.
REQ-027 Read-after-write: refill following a completed write-back to same line SHALL return the written data.

Reset
REQ-028 On rst_i: state IDLE, counters 0, req_ready_o=1 next cycle; rvalid_o, wready_o, last_o, done_o, beat_offset_o, rdata_o = 0.
REQ-029 Reset mid-burst SHALL abort the burst without done_o; memory contents SHALL NOT be cleared (partially written words persist).

Structure
REQ-030 State enum and LINE_SIZE derivation SHALL live in the shared cache package/header alongside `CACHE_B/`CACHE_T.
REQ-031 Backing store SHALL be a separate sub-module mem_array (one sync-write, async-read port); FSM and counters in top.

Verification (CACHE_B=4 -> LINE_SIZE=4, ADDR_WIDTH=10, LATENCY=2)
REQ-032 Write req addr 0x40, beats 0xA0..0xA3 continuous -> wready_o 2 cycles after accept, done_o pulse 1 cycle after 4th beat.
REQ-033 Refill addr 0x4C -> 2 WAIT cycles, then rvalid_o 4 cycles with offsets 0..3, data 0xA0..0xA3, last_o on 0xA3, then done_o.
REQ-034 Write burst with wvalid_i low on beat 1 for 3 cycles -> beat_offset_o holds 1, memory correct, total WRITE cycles = 7.
REQ-035 rst_i asserted on 2nd refill beat -> all outputs 0 next cycle, no done_o, req_ready_o=1; new request accepted normally.
REQ-036 LATENCY=0, refill addr 0x1000 (wraps to word 0) -> rvalid_o cycle after accept, data from words 0..3.
REQ-037 req_valid_i held high during busy burst -> second request accepted only the cycle after done_o.
